fetch_stage: RTL and testbench
==============================

# fetch_stage

Fetch stage and IF/ID pipeline register, the consumer of the decode-stage `freeze_pc` stall request. It owns the PC, reads instruction memory, assembles one- and two-word instructions, and holds or flushes the IF/ID register. It also generates the ID/EX bubble that accompanies a load-use stall.

## Interface
- `PC_W`, 32, PC and instruction-memory address width (word addressed)
- `INSTR_W`, 16, instruction word width
- `RESET_PC`, 0, PC value loaded by reset

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `freeze_pc`  in  1  stall request from hazard detection; one-cycle pulse per load-use hazard
- `redirect_en`  in  1  branch/call/return taken; load `redirect_pc`
- `redirect_pc`  in  PC_W  redirect target
- `imem_addr`  out  PC_W  instruction-memory address; equals PC
- `imem_data`  in  INSTR_W  combinational read data for `imem_addr`, same cycle
- `if_id_instr`  out  INSTR_W  registered instruction word
- `if_id_imm`  out  INSTR_W  registered immediate word; 0 for one-word instructions
- `if_id_pc`  out  PC_W  address of the first word of `if_id_instr`
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `id_ex_bubble`  out  1  force NOP into ID/EX this cycle
- `stall_count`  out  16  freeze-cycle counter. Exists only with `FETCH_STALL_CNT_EN`.

## Operation
- Opcode is `imem_data[15:11]`.
- Two-word opcodes: 5'b10001, 5'b10010, 5'b10011, 5'b11000, 5'b11001. Every other opcode is one-word.
- FSM states:
  - S_WORD0: fetch the first word.
  - S_WORD1: fetch the immediate word.
- S_WORD0, one-word opcode, no freeze or redirect:
  - IF/ID ← {instr, imm=0, pc, valid=1}.
  - PC ← PC+1.
  - Stay in S_WORD0.
- S_WORD0, two-word opcode:
  - The word is latched internally, along with its PC.
  - IF/ID valid ← 0, inserting a bubble.
  - PC ← PC+1.
  - Go to S_WORD1.
- S_WORD1:
  - IF/ID ← {latched word, imm=imem_data, latched pc, valid=1}.
  - PC ← PC+1.
  - Go to S_WORD0.
- Freeze (`freeze_pc`=1, `redirect_en`=0):
  - PC, FSM state, IF/ID and the latched word all hold.
  - `id_ex_bubble`=1.
- Redirect (`redirect_en`=1):
  - PC ← `redirect_pc`.
  - IF/ID valid ← 0; instr, imm and pc fields are cleared to 0.
  - Any partially assembled two-word instruction is discarded.
  - FSM ← S_WORD0.
- Redirect and freeze in the same cycle: redirect wins, and `id_ex_bubble`=0.
- PC arithmetic is modulo 2^PC_W. Incrementing from all-ones wraps to 0 with no flag.

## Timing
- Reset values, after the first rising edge with `rst`=1:
  - PC=`RESET_PC`.
  - FSM=S_WORD0.
  - `if_id_instr`=0, `if_id_imm`=0, `if_id_pc`=0, `if_id_valid`=0.
  - `stall_count`=0.
- `rst` has priority over `redirect_en` and `freeze_pc`.
- `rst` asserted mid two-word fetch discards the partial instruction.
- `imem_addr` is combinational from the PC register.
- `id_ex_bubble` = `freeze_pc` & ~`redirect_en`, combinational, with no register.
- Latency:
  - One-word instruction: appears on IF/ID one cycle after its address is presented.
  - Two-word instruction: appears two cycles after its first address, preceded by one invalid IF/ID cycle.
- Back-to-back `freeze_pc` pulses each hold for exactly one further cycle. No limit on consecutive freezes.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_count` port and counter are present.
  - The counter increments on every cycle with `freeze_pc`=1 and `redirect_en`=0.
  - It saturates at 16'hFFFF and clears only on `rst`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state enum (S_WORD0, S_WORD1);
  - the `OPC_HI`/`OPC_LO` bit indices;
  - the two-word opcode constants;
  - the `is_two_word(opcode)` function.
- One sub-module, `if_id_reg`: the IF/ID register with hold and flush inputs, and flush priority over hold.

## Test plan
- Reset, then memory = [0x0800, 0x1000, 0x1800] (one-word): IF/ID pc=0,1,2 on consecutive cycles, valid=1; `imem_addr` 0→1→2→3.
- Memory[4]=0x9000 (opcode 10010), memory[5]=0x0042:
  - first cycle: valid=0, PC 4→5;
  - next cycle: instr=0x9000, imm=0x0042, pc=4, valid=1; PC=6.
- `freeze_pc` pulse with PC=7:
  - `id_ex_bubble`=1 that cycle;
  - PC stays 7 and IF/ID is unchanged for one cycle;
  - fetch resumes at 7 the following cycle.
- `redirect_en`=1 with `redirect_pc`=0x20 and `freeze_pc`=1 in S_WORD1:
  - `id_ex_bubble`=0;
  - next cycle PC=0x20, valid=0, FSM=S_WORD0.
- PC=0xFFFFFFFF with a one-word instruction: next PC=0.
- `FETCH_STALL_CNT_EN`:
  - 3 freeze pulses plus 1 freeze coincident with a redirect → `stall_count`=3;
  - forcing the counter to 0xFFFF and freezing again → stays 0xFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and opcode decode helpers.
package fetch_pkg;

    typedef enum logic {
        S_WORD0 = 1'b0,
        S_WORD1 = 1'b1
    } fetch_state_e;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 11;

    localparam logic [4:0] OPC_TW_A = 5'b10001;
    localparam logic [4:0] OPC_TW_B = 5'b10010;
    localparam logic [4:0] OPC_TW_C = 5'b10011;
    localparam logic [4:0] OPC_TW_D = 5'b11000;
    localparam logic [4:0] OPC_TW_E = 5'b11001;

    function automatic logic is_two_word(input logic [4:0] opcode);
        return (opcode == OPC_TW_A) || (opcode == OPC_TW_B) || (opcode == OPC_TW_C) ||
               (opcode == OPC_TW_D) || (opcode == OPC_TW_E);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register; flush clears all fields and takes priority over hold.
module if_id_reg #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               hold_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] imm_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic               valid_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] imm_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] imm_q;
    logic [PC_W-1:0]    pc_q;
    logic               valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            instr_q <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            instr_q <= instr_i;
            imm_q   <= imm_i;
            pc_q    <= pc_i;
            valid_q <= valid_i;
        end
    end

    assign instr_o = instr_q;
    assign imm_o   = imm_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, one/two-word instruction assembly and IF/ID register.
// Optional freeze-cycle counter enabled by FETCH_STALL_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze_pc,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               id_ex_bubble
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] word_q, word_d;
    logic [PC_W-1:0]    wpc_q, wpc_d;

    logic               hold;
    logic [INSTR_W-1:0] ld_instr;
    logic [INSTR_W-1:0] ld_imm;
    logic [PC_W-1:0]    ld_pc;
    logic               ld_valid;

    assign hold         = freeze_pc & ~redirect_en;
    assign id_ex_bubble = hold;
    assign imem_addr    = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WORD0;
            pc_q    <= RESET_PC;
            word_q  <= '0;
            wpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            wpc_q   <= wpc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        word_d   = word_q;
        wpc_d    = wpc_q;
        ld_instr = '0;
        ld_imm   = '0;
        ld_pc    = '0;
        ld_valid = 1'b0;
        if (redirect_en) begin
            pc_d    = redirect_pc;
            state_d = S_WORD0;
        end else if (!freeze_pc) begin
            pc_d = pc_q + 1'b1;
            case (state_q)
                S_WORD0: begin
                    if (is_two_word(imem_data[OPC_HI:OPC_LO])) begin
                        word_d  = imem_data;
                        wpc_d   = pc_q;
                        state_d = S_WORD1;
                    end else begin
                        ld_instr = imem_data;
                        ld_pc    = pc_q;
                        ld_valid = 1'b1;
                    end
                end
                S_WORD1: begin
                    ld_instr = word_q;
                    ld_imm   = imem_data;
                    ld_pc    = wpc_q;
                    ld_valid = 1'b1;
                    state_d  = S_WORD0;
                end
                default: state_d = S_WORD0;
            endcase
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (redirect_en),
        .hold_i  (hold),
        .instr_i (ld_instr),
        .imm_i   (ld_imm),
        .pc_i    (ld_pc),
        .valid_i (ld_valid),
        .instr_o (if_id_instr),
        .imm_o   (if_id_imm),
        .pc_o    (if_id_pc),
        .valid_o (if_id_valid)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (hold && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model plus directed literal checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze_pc;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_imm;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        id_ex_bubble;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_W     (32),
        .INSTR_W  (16),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze_pc    (freeze_pc),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .if_id_instr  (if_id_instr),
        .if_id_imm    (if_id_imm),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .id_ex_bubble (id_ex_bubble)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    // 64-word instruction memory, address aliased on the low 6 bits
    logic [15:0] mem [64];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0]  = 16'h0800;
        mem[1]  = 16'h1000;
        mem[2]  = 16'h1800;
        mem[3]  = 16'h2000;
        mem[4]  = 16'h9000;
        mem[5]  = 16'h0042;
        mem[6]  = 16'h2800;
        mem[7]  = 16'h3000;
        mem[8]  = 16'h8800;
        mem[9]  = 16'h1234;
        mem[32] = 16'hC000;
        mem[33] = 16'h00AB;
        mem[63] = 16'h0700;
    end

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        return mem[a[5:0]];
    endfunction

    always_comb imem_data = mem_rd(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model of the fetch rules
    logic [31:0] m_pc;
    bit          m_pend;
    logic [15:0] m_pword;
    logic [31:0] m_ppc;
    bit          m_valid;
    logic [15:0] m_instr, m_imm;
    logic [31:0] m_ifpc;
    int          m_cnt;
    bit          live = 1'b0;

    function automatic bit two_word(input logic [15:0] w);
        logic [4:0] op;
        op = w[15:11];
        return op inside {5'b10001, 5'b10010, 5'b10011, 5'b11000, 5'b11001};
    endfunction

    always @(posedge clk) begin
        logic [15:0] w;
        if (rst) begin
            m_pc = 32'h0; m_pend = 0; m_valid = 0;
            m_instr = 0; m_imm = 0; m_ifpc = 0; m_cnt = 0;
            live = 1'b1;
        end else if (redirect_en) begin
            m_pc = redirect_pc; m_pend = 0; m_valid = 0;
            m_instr = 0; m_imm = 0; m_ifpc = 0;
        end else if (freeze_pc) begin
            if (m_cnt < 65535) m_cnt++;
        end else begin
            w = mem_rd(m_pc);
            if (m_pend) begin
                m_valid = 1; m_instr = m_pword; m_imm = w; m_ifpc = m_ppc; m_pend = 0;
            end else if (two_word(w)) begin
                m_pend = 1; m_pword = w; m_ppc = m_pc; m_valid = 0;
            end else begin
                m_valid = 1; m_instr = w; m_imm = 0; m_ifpc = m_pc;
            end
            m_pc = m_pc + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (live && !rst) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            chk("m_bubble", {31'd0, id_ex_bubble}, {31'd0, freeze_pc & ~redirect_en});
            if (m_valid) begin
                chk("m_instr", {16'd0, if_id_instr}, {16'd0, m_instr});
                chk("m_imm", {16'd0, if_id_imm}, {16'd0, m_imm});
                chk("m_ifpc", if_id_pc, m_ifpc);
            end
`ifdef FETCH_STALL_CNT_EN
            chk("m_stall_cnt", {16'd0, stall_count}, 32'(m_cnt));
`endif
        end
    end

    task automatic step(input bit f, input bit r, input logic [31:0] rpc);
        freeze_pc   = f;
        redirect_en = r;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
        freeze_pc   = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
    endtask

    initial begin
        rst = 1'b1; freeze_pc = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", {16'd0, if_id_instr}, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);

        step(0, 0, 0);
        chk("w1_pc", if_id_pc, 32'd0);
        chk("w1_instr", {16'd0, if_id_instr}, 32'h0800);
        chk("w1_addr", imem_addr, 32'd1);
        step(0, 0, 0);
        chk("w2_pc", if_id_pc, 32'd1);
        step(0, 0, 0);
        chk("w3_pc", if_id_pc, 32'd2);
        chk("w3_addr", imem_addr, 32'd3);
        step(0, 0, 0);

        step(0, 0, 0);
        chk("tw_bubble_valid", {31'd0, if_id_valid}, 32'd0);
        chk("tw_addr5", imem_addr, 32'd5);
        step(0, 0, 0);
        chk("tw_instr", {16'd0, if_id_instr}, 32'h9000);
        chk("tw_imm", {16'd0, if_id_imm}, 32'h0042);
        chk("tw_pc", if_id_pc, 32'd4);
        chk("tw_addr6", imem_addr, 32'd6);
        step(0, 0, 0);

        freeze_pc = 1'b1;
        #2;
        chk("frz_bubble", {31'd0, id_ex_bubble}, 32'd1);
        @(posedge clk); #1;
        freeze_pc = 1'b0;
        chk("frz_addr", imem_addr, 32'd7);
        chk("frz_hold_pc", if_id_pc, 32'd6);
        step(0, 0, 0);
        chk("frz_resume_pc", if_id_pc, 32'd7);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("frz2_addr", imem_addr, 32'd8);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("frz_w1_addr", imem_addr, 32'd9);

        freeze_pc = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h20;
        #2;
        chk("rd_bubble", {31'd0, id_ex_bubble}, 32'd0);
        @(posedge clk); #1;
        freeze_pc = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
        chk("rd_addr", imem_addr, 32'h20);
        chk("rd_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rd_instr", {16'd0, if_id_instr}, 32'd0);
        chk("rd_imm", {16'd0, if_id_imm}, 32'd0);
        chk("rd_pc", if_id_pc, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt4", {16'd0, stall_count}, 32'd4);
`endif
        step(0, 0, 0);
        chk("rd_w0_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0);
        chk("rd_tw_instr", {16'd0, if_id_instr}, 32'hC000);
        chk("rd_tw_imm", {16'd0, if_id_imm}, 32'h00AB);
        chk("rd_tw_pc", if_id_pc, 32'h20);

        step(0, 1, 32'hFFFF_FFFF);
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFF);
        step(0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFF);
        chk("wrap_instr", {16'd0, if_id_instr}, 32'h0700);

`ifdef FETCH_STALL_CNT_EN
        force dut.stall_q = 16'hFFFF;
        #1;
        release dut.stall_q;
        m_cnt = 65535;
        step(1, 0, 0);
        chk("stall_sat", {16'd0, stall_count}, 32'hFFFF);
        step(0, 0, 0);
`endif

        step(0, 1, 32'd4);
        step(0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_addr", imem_addr, 32'd0);
        chk("mrst_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("mrst_stall", {16'd0, stall_count}, 32'd0);
`endif
        step(0, 0, 0);
        chk("mrst_instr", {16'd0, if_id_instr}, 32'h0800);
        chk("mrst_pc", if_id_pc, 32'd0);
        chk("mrst_valid1", {31'd0, if_id_valid}, 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
